cache_fill_way_demux: RTL and testbench
=======================================

# cache_fill_way_demux

Write-side counterpart of the cache's four-way read select. It accepts a line-fill request for one set, picks the victim way, and streams the fill beats into that way. The victim is the lowest-lettered invalid way, otherwise a per-set tree pseudo-LRU choice. The result drives one-hot way write enables into the four data/tag arrays. The block sits between the miss/refill controller and the way arrays, and it also consumes hit notifications so the replacement state tracks accesses.

## Interface
- DATA_WIDTH, 32, width of one fill beat / array write word
- INDEX_WIDTH, 4, set index width (2**INDEX_WIDTH sets)
- OFFSET_WIDTH, 2, beat offset width; beats per line = 2**OFFSET_WIDTH (minimum 1)

Ports:
- i_clk  in  1  single clock; all logic on the rising edge
- i_rst  in  1  synchronous, active-high reset
- i_flush  in  1  clear all valid bits and PLRU state; aborts any fill in progress
- i_req_valid  in  1  fill request present
- o_req_ready  out  1  high only in IDLE
- i_req_index  in  INDEX_WIDTH  set to fill
- i_beat_valid  in  1  fill beat present
- o_beat_ready  out  1  high only in FILL
- i_beat_data  in  DATA_WIDTH  fill beat payload
- i_hit_valid  in  1  a read hit occurred this cycle
- i_hit_index  in  INDEX_WIDTH  set of the hit
- i_hit_sel_a / _b / _c / _d  in  1 each  way of the hit; priority a>b>c>d when more than one is set
- o_we_a / _b / _c / _d  out  1 each  registered one-hot way write enable
- o_wr_index  out  INDEX_WIDTH  registered write set
- o_wr_offset  out  OFFSET_WIDTH  registered beat offset
- o_wr_data  out  DATA_WIDTH  registered write data
- o_victim_way  out  2  victim encoding (0=a … 3=d); meaningful in FILL and DONE
- o_done  out  1  one-cycle pulse, coincident with the last beat write

## Operation
- States: IDLE, FILL, DONE.
  - IDLE → FILL on i_req_valid & o_req_ready. The same edge latches the index, computes the victim, registers o_victim_way and clears the beat counter.
  - FILL: each i_beat_valid & o_beat_ready beat increments the counter. The beat accepted at counter = 2**OFFSET_WIDTH−1 moves the block to DONE.
  - DONE lasts exactly one cycle, then the block returns to IDLE.
- Victim choice, evaluated at request acceptance:
  - If any way is invalid, pick the first invalid way in order a, b, c, d.
  - Otherwise follow the PLRU tree. b0=0 → choose between a/b using b1 (0→a, 1→b). b0=1 → choose between c/d using b2 (0→c, 1→d).
- PLRU update on an access to a way (points the tree away from it):
  - a: b0=1, b1=1
  - b: b0=1, b1=0
  - c: b0=0, b2=1
  - d: b0=0, b2=0
- Update sources:
  - A hit updates its set on the edge after i_hit_valid.
  - A completed fill updates the victim's set and sets that way's valid bit on the edge leaving DONE.
  - If both target the same set on the same edge, the fill update wins. Updates to different sets both apply.
- Write path: a beat accepted on edge N drives o_we_<victim>=1, o_wr_data, o_wr_offset = counter value at acceptance, and o_wr_index during cycle N+1. The enable is 0 in cycles with no accepted beat. At most one enable is ever high.
- Flush has priority over everything. On the next edge:
  - valid bits and PLRU bits go to 0
  - state goes to IDLE, counter clears
  - o_we_*, o_done and o_wr_* go to 0
  - a concurrent request or beat is dropped
  - hits in the flush cycle are ignored
- Reset gives the same result as flush. Reset values of all outputs:
  - o_req_ready=1
  - o_beat_ready=0
  - o_we_a..d=0
  - o_wr_index=0, o_wr_offset=0, o_wr_data=0
  - o_victim_way=0
  - o_done=0

## Timing
- Request accepted at edge T: FILL from T+1. With back-to-back beats, the beats are accepted at T+1 … T+B (B = beat count), and writes are visible in cycles T+2 … T+B+1.
- DONE is the cycle after the last beat is accepted. In that cycle o_done=1, together with the last o_we.
- o_req_ready returns high in the cycle after DONE. The minimum request-to-request spacing is therefore B+2 cycles.
- Gaps in i_beat_valid stall the counter. There is no timeout.
- A flush asserted while in DONE aborts the fill: the valid bit is not set and the PLRU is not updated.

## Test plan
- Reset, then fill set 3 with beats 0x11, 0x22, 0x33, 0x44 back-to-back.
  - o_victim_way=0; o_we_a high for 4 cycles at offsets 0–3 with that data; o_done on the 4th write.
- Fill set 3 three more times.
  - Victims are b, c, d in order.
  - A fifth fill selects PLRU: after fills a,b,c,d the bits are b0=0, b1=0 → victim a.
- All four ways of set 5 valid; hits on a then c.
  - Next fill of set 5 picks b (b0=1 from hit a was overridden by hit c → b0=0, b1=1 → b).
- Same-set hit on way a plus fill completion of way d on the same edge.
  - Resulting bits reflect the d update: b0=0, b2=0, and b1 is unchanged.
- Beats with a 3-cycle i_beat_valid gap mid-line.
  - Offsets stay contiguous 0–3; no o_we during the gap; o_done only after beat 4.
- i_flush after 2 of 4 beats.
  - Next cycle o_we_*=0 and o_req_ready=1.
  - The next fill of any set picks way a and writes offsets starting at 0.

Source files
------------

// File: rtl/cache_fill_way_demux.sv
// Fill-side way demux for a four-way cache: picks a victim way per set
// and streams refill beats into it as one-hot registered write enables.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_flush            clears valid/PLRU state, aborts any fill
//   i_req_*/o_req_ready    line-fill request (accepted only in IDLE)
//   i_beat_*/o_beat_ready  fill beats (accepted only in FILL)
//   i_hit_*            read-hit notification for PLRU tracking
//   o_we_a..d, o_wr_*  registered array write port
//   o_victim_way       victim of the current fill (0=a .. 3=d)
//   o_done             pulse coincident with the last beat write
module cache_fill_way_demux #(
    parameter int DATA_WIDTH   = 32,
    parameter int INDEX_WIDTH  = 4,
    parameter int OFFSET_WIDTH = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_flush,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic [INDEX_WIDTH-1:0]  i_req_index,
    input  logic                    i_beat_valid,
    output logic                    o_beat_ready,
    input  logic [DATA_WIDTH-1:0]   i_beat_data,
    input  logic                    i_hit_valid,
    input  logic [INDEX_WIDTH-1:0]  i_hit_index,
    input  logic                    i_hit_sel_a,
    input  logic                    i_hit_sel_b,
    input  logic                    i_hit_sel_c,
    input  logic                    i_hit_sel_d,
    output logic                    o_we_a,
    output logic                    o_we_b,
    output logic                    o_we_c,
    output logic                    o_we_d,
    output logic [INDEX_WIDTH-1:0]  o_wr_index,
    output logic [OFFSET_WIDTH-1:0] o_wr_offset,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic [1:0]              o_victim_way,
    output logic                    o_done
);

    localparam int NUM_SETS = 1 << INDEX_WIDTH;
    localparam logic [OFFSET_WIDTH-1:0] LAST_BEAT = '1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                         state_q, state_d;
    logic [OFFSET_WIDTH-1:0]        cnt_q, cnt_d;
    logic [INDEX_WIDTH-1:0]         idx_q, idx_d;
    logic [1:0]                     victim_q, victim_d;
    // PLRU bits per set: [0]=b0 (a/b vs c/d), [1]=b1 (a vs b), [2]=b2 (c vs d)
    logic [NUM_SETS-1:0][3:0]       valid_q, valid_d;
    logic [NUM_SETS-1:0][2:0]       plru_q, plru_d;
    logic [3:0]                     we_q, we_d;
    logic [INDEX_WIDTH-1:0]         wr_index_q, wr_index_d;
    logic [OFFSET_WIDTH-1:0]        wr_offset_q, wr_offset_d;
    logic [DATA_WIDTH-1:0]          wr_data_q, wr_data_d;
    logic                           done_q, done_d;

    logic                           hit_any;
    logic [1:0]                     hit_way;

    // Point the tree away from the accessed way.
    function automatic logic [2:0] plru_touch(input logic [2:0] bits,
                                              input logic [1:0] way);
        logic [2:0] r;
        r = bits;
        case (way)
            2'd0: begin r[0] = 1'b1; r[1] = 1'b1; end
            2'd1: begin r[0] = 1'b1; r[1] = 1'b0; end
            2'd2: begin r[0] = 1'b0; r[2] = 1'b1; end
            default: begin r[0] = 1'b0; r[2] = 1'b0; end
        endcase
        return r;
    endfunction

    // First invalid way wins; otherwise walk the tree.
    function automatic logic [1:0] pick_victim(input logic [3:0] vld,
                                               input logic [2:0] bits);
        logic [1:0] w;
        if (!vld[0])       w = 2'd0;
        else if (!vld[1])  w = 2'd1;
        else if (!vld[2])  w = 2'd2;
        else if (!vld[3])  w = 2'd3;
        else if (!bits[0]) w = {1'b0, bits[1]};
        else               w = {1'b1, bits[2]};
        return w;
    endfunction

    always_comb begin
        hit_any = i_hit_sel_a | i_hit_sel_b | i_hit_sel_c | i_hit_sel_d;
        if (i_hit_sel_a)      hit_way = 2'd0;
        else if (i_hit_sel_b) hit_way = 2'd1;
        else if (i_hit_sel_c) hit_way = 2'd2;
        else                  hit_way = 2'd3;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        victim_d    = victim_q;
        valid_d     = valid_q;
        plru_d      = plru_q;
        we_d        = '0;
        wr_index_d  = wr_index_q;
        wr_offset_d = wr_offset_q;
        wr_data_d   = wr_data_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req_valid) begin
                    state_d  = ST_FILL;
                    idx_d    = i_req_index;
                    victim_d = pick_victim(valid_q[i_req_index],
                                           plru_q[i_req_index]);
                    cnt_d    = '0;
                end
            end
            ST_FILL: begin
                if (i_beat_valid) begin
                    we_d        = 4'b0001 << victim_q;
                    wr_index_d  = idx_q;
                    wr_offset_d = cnt_q;
                    wr_data_d   = i_beat_data;
                    cnt_d       = cnt_q + 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_hit_valid && hit_any) begin
            plru_d[i_hit_index] = plru_touch(plru_q[i_hit_index], hit_way);
        end

        // Applied after the hit so a same-set fill overrides it entirely,
        // computed from the pre-hit bits.
        if (state_q == ST_DONE) begin
            plru_d[idx_q]            = plru_touch(plru_q[idx_q], victim_q);
            valid_d[idx_q][victim_q] = 1'b1;
        end

        if (i_flush) begin
            state_d     = ST_IDLE;
            cnt_d       = '0;
            idx_d       = '0;
            victim_d    = '0;
            valid_d     = '0;
            plru_d      = '0;
            we_d        = '0;
            wr_index_d  = '0;
            wr_offset_d = '0;
            wr_data_d   = '0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            victim_q    <= '0;
            valid_q     <= '0;
            plru_q      <= '0;
            we_q        <= '0;
            wr_index_q  <= '0;
            wr_offset_q <= '0;
            wr_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            victim_q    <= victim_d;
            valid_q     <= valid_d;
            plru_q      <= plru_d;
            we_q        <= we_d;
            wr_index_q  <= wr_index_d;
            wr_offset_q <= wr_offset_d;
            wr_data_q   <= wr_data_d;
            done_q      <= done_d;
        end
    end

    assign o_req_ready  = (state_q == ST_IDLE);
    assign o_beat_ready = (state_q == ST_FILL);
    assign o_we_a       = we_q[0];
    assign o_we_b       = we_q[1];
    assign o_we_c       = we_q[2];
    assign o_we_d       = we_q[3];
    assign o_wr_index   = wr_index_q;
    assign o_wr_offset  = wr_offset_q;
    assign o_wr_data    = wr_data_q;
    assign o_victim_way = victim_q;
    assign o_done       = done_q;

endmodule

// File: tb/tb_cache_fill_way_demux.sv
// Bench for cache_fill_way_demux: directed scenarios with literal
// expectations, then random traffic against a behavioural model.
module tb_cache_fill_way_demux;

    localparam int DW    = 32;
    localparam int IW    = 4;
    localparam int OW    = 2;
    localparam int SETS  = 16;
    localparam int BEATS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [IW-1:0] req_index = '0;
    logic          beat_valid = 1'b0;
    logic          beat_ready;
    logic [DW-1:0] beat_data = '0;
    logic          hit_valid = 1'b0;
    logic [IW-1:0] hit_index = '0;
    logic          sa = 1'b0, sb = 1'b0, sc = 1'b0, sd = 1'b0;
    logic          wa, wb, wc, wd;
    logic [IW-1:0] wr_index;
    logic [OW-1:0] wr_offset;
    logic [DW-1:0] wr_data;
    logic [1:0]    victim;
    logic          done;

    always #5 clk = ~clk;

    cache_fill_way_demux #(
        .DATA_WIDTH(DW), .INDEX_WIDTH(IW), .OFFSET_WIDTH(OW)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(flush),
        .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_index(req_index),
        .i_beat_valid(beat_valid), .o_beat_ready(beat_ready),
        .i_beat_data(beat_data),
        .i_hit_valid(hit_valid), .i_hit_index(hit_index),
        .i_hit_sel_a(sa), .i_hit_sel_b(sb),
        .i_hit_sel_c(sc), .i_hit_sel_d(sd),
        .o_we_a(wa), .o_we_b(wb), .o_we_c(wc), .o_we_d(wd),
        .o_wr_index(wr_index), .o_wr_offset(wr_offset),
        .o_wr_data(wr_data), .o_victim_way(victim), .o_done(done)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [3:0]  mval [SETS];
    bit [2:0]  mplru [SETS];   // [0]=b0 [1]=b1 [2]=b2
    int        phase = 0;      // 0 idle, 1 filling, 2 last write shown
    int        m_idx = 0, m_vic = 0, m_cnt = 0;
    bit [3:0]  e_we = '0;
    bit        e_done = 1'b0;
    bit        e_req_ready = 1'b1, e_beat_ready = 1'b0;
    int        e_victim = 0, e_wr_index = 0, e_wr_offset = 0;
    bit [31:0] e_wr_data = '0;
    bit [2:0]  old_fill;
    bit        finishing;
    int        hw;

    function automatic bit [2:0] touch(input bit [2:0] p, input int w);
        bit [2:0] r;
        r = p;
        if (w == 0)      begin r[0] = 1; r[1] = 1; end
        else if (w == 1) begin r[0] = 1; r[1] = 0; end
        else if (w == 2) begin r[0] = 0; r[2] = 1; end
        else             begin r[0] = 0; r[2] = 0; end
        return r;
    endfunction

    function automatic int choose(input int s);
        for (int w = 0; w < 4; w++)
            if (!mval[s][w]) return w;
        if (mplru[s][0] == 0) return mplru[s][1] ? 1 : 0;
        return mplru[s][2] ? 3 : 2;
    endfunction

    always @(posedge clk) begin
        if (rst || flush) begin
            for (int s = 0; s < SETS; s++) begin
                mval[s]  = '0;
                mplru[s] = '0;
            end
            phase = 0; m_cnt = 0;
            e_we = '0; e_done = 0; e_victim = 0;
            e_wr_index = 0; e_wr_offset = 0; e_wr_data = '0;
        end else begin
            old_fill  = mplru[m_idx];
            finishing = (phase == 2);
            e_we   = '0;
            e_done = 0;
            if (phase == 0) begin
                if (req_valid) begin
                    m_idx = int'(req_index);
                    m_vic = choose(m_idx);
                    m_cnt = 0;
                    phase = 1;
                    e_victim = m_vic;
                end
            end else if (phase == 1) begin
                if (beat_valid) begin
                    e_we[m_vic]  = 1'b1;
                    e_wr_index   = m_idx;
                    e_wr_offset  = m_cnt;
                    e_wr_data    = beat_data;
                    m_cnt++;
                    if (m_cnt == BEATS) begin
                        phase  = 2;
                        e_done = 1;
                    end
                end
            end else begin
                phase = 0;
            end
            if (hit_valid && (sa | sb | sc | sd)) begin
                hw = sa ? 0 : sb ? 1 : sc ? 2 : 3;
                mplru[hit_index] = touch(mplru[hit_index], hw);
            end
            if (finishing) begin
                mplru[m_idx] = touch(old_fill, m_vic);
                mval[m_idx][m_vic] = 1'b1;
            end
        end
        e_req_ready  = (phase == 0);
        e_beat_ready = (phase == 1);
    end

    always @(negedge clk) begin
        chk("req_ready", 64'(req_ready), 64'(e_req_ready));
        chk("beat_ready", 64'(beat_ready), 64'(e_beat_ready));
        chk("we", 64'({wd, wc, wb, wa}), 64'(e_we));
        chk("done", 64'(done), 64'(e_done));
        if (e_we != 0) begin
            chk("wr_index", 64'(wr_index), 64'(e_wr_index));
            chk("wr_offset", 64'(wr_offset), 64'(e_wr_offset));
            chk("wr_data", 64'(wr_data), 64'(e_wr_data));
        end
        if (phase != 0) chk("victim", 64'(victim), 64'(e_victim));
    end

    // ---------------- write monitor for literal checks ----------------
    typedef struct {
        int way; int off; int data; bit dn;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk) begin
        if (wa | wb | wc | wd) begin
            wr_t w;
            w.way  = wa ? 0 : wb ? 1 : wc ? 2 : 3;
            w.off  = int'(wr_offset);
            w.data = int'(wr_data);
            w.dn   = done;
            wq.push_back(w);
        end
    end

    function automatic logic [63:0] pack_wr(input int way, input int off,
                                            input bit dn, input int data);
        return (64'(way) << 40) | (64'(off) << 36) | (64'(dn) << 32)
               | 64'(unsigned'(data));
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic do_fill(input int idx, input int gap_at, input int gap_len,
                           input bit hit_done, output int vic);
        @(negedge clk);
        req_valid = 1'b1;
        req_index = IW'(idx);
        @(negedge clk);
        req_valid = 1'b0;
        vic = int'(victim);
        for (int b = 0; b < BEATS; b++) begin
            if (b == gap_at) begin
                beat_valid = 1'b0;
                repeat (gap_len) @(negedge clk);
            end
            beat_valid = 1'b1;
            beat_data  = DW'((b + 1) * 32'h11);
            @(negedge clk);
        end
        beat_valid = 1'b0;
        if (hit_done) begin
            hit_valid = 1'b1;
            hit_index = IW'(idx);
            sa = 1'b1;
        end
        @(negedge clk);
        hit_valid = 1'b0;
        sa = 1'b0;
    endtask

    task automatic do_hit(input int idx, input bit [3:0] sel);
        @(negedge clk);
        hit_valid = 1'b1;
        hit_index = IW'(idx);
        {sd, sc, sb, sa} = sel;
        @(negedge clk);
        hit_valid = 1'b0;
        {sd, sc, sb, sa} = 4'b0;
    endtask

    int v;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_victim", 64'(victim), 64'd0);
        rst = 1'b0;

        // first fill of set 3: way a, offsets 0..3, done on last
        wq.delete();
        do_fill(3, -1, 0, 0, v);
        chk("f1_victim", 64'(v), 64'd0);
        chk("f1_nwr", 64'(wq.size()), 64'd4);
        if (wq.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("f1_wr", pack_wr(wq[i].way, wq[i].off, wq[i].dn, wq[i].data),
                    pack_wr(0, i, i == 3, (i + 1) * 32'h11));

        do_fill(3, -1, 0, 0, v); chk("f2_victim", 64'(v), 64'd1);
        do_fill(3, -1, 0, 0, v); chk("f3_victim", 64'(v), 64'd2);
        do_fill(3, -1, 0, 0, v); chk("f4_victim", 64'(v), 64'd3);
        do_fill(3, -1, 0, 0, v); chk("f5_plru", 64'(v), 64'd0);

        // set 5: all valid, hit a then c -> b
        for (int i = 0; i < 4; i++) do_fill(5, -1, 0, 0, v);
        do_hit(5, 4'b0001);
        do_hit(5, 4'b0100);
        do_fill(5, -1, 0, 0, v);
        chk("hit_plru", 64'(v), 64'd1);

        // set 6: fill d with same-edge hit on a; fill wins -> next is a
        for (int i = 0; i < 3; i++) do_fill(6, -1, 0, 0, v);
        do_fill(6, -1, 0, 1, v);
        chk("col_victim", 64'(v), 64'd3);
        do_fill(6, -1, 0, 0, v);
        chk("col_plru", 64'(v), 64'd0);

        // set 9: three-cycle beat gap mid-line
        wq.delete();
        do_fill(9, 2, 3, 0, v);
        chk("gap_nwr", 64'(wq.size()), 64'd4);
        if (wq.size() == 4)
            for (int i = 0; i < 4; i++)
                chk("gap_wr", pack_wr(wq[i].way, wq[i].off, wq[i].dn, wq[i].data),
                    pack_wr(0, i, i == 3, (i + 1) * 32'h11));

        // flush after two of four beats
        @(negedge clk);
        req_valid = 1'b1; req_index = 4'd3;
        @(negedge clk);
        req_valid = 1'b0; beat_valid = 1'b1; beat_data = 32'hA1;
        @(negedge clk);
        beat_data = 32'hA2;
        @(negedge clk);
        flush = 1'b1; req_valid = 1'b1;
        @(negedge clk);
        chk("flush_we", 64'({wd, wc, wb, wa}), 64'd0);
        chk("flush_ready", 64'(req_ready), 64'd1);
        flush = 1'b0; req_valid = 1'b0; beat_valid = 1'b0;
        wq.delete();
        do_fill(3, -1, 0, 0, v);
        chk("flush_victim", 64'(v), 64'd0);
        chk("flush_nwr", 64'(wq.size()), 64'd4);
        if (wq.size() > 0)
            chk("flush_first", pack_wr(wq[0].way, wq[0].off, 0, 0),
                pack_wr(0, 0, 0, 0));

        // random traffic on a few sets to force conflicts
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 399) == 0);
            flush      = ($urandom_range(0, 59) == 0);
            req_valid  = ($urandom_range(0, 3) == 0);
            req_index  = IW'($urandom_range(0, 3));
            beat_valid = ($urandom_range(0, 9) < 7);
            beat_data  = $urandom;
            hit_valid  = ($urandom_range(0, 3) == 0);
            hit_index  = IW'($urandom_range(0, 3));
            {sd, sc, sb, sa} = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        rst = 1'b0; flush = 1'b0; req_valid = 1'b0;
        beat_valid = 1'b0; hit_valid = 1'b0;
        {sd, sc, sb, sa} = 4'b0;
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
